// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: two debounced push-buttons (step, mode) plus an optional
// timed auto-step drive four LED patterns (alternate, chase, bounce, binary count).
module led_pattern_seq #(
    parameter int N_LED           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_DIV        = 25000000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             key_step,
    input  logic             key_mode,
    input  logic             auto_en,
    output logic [N_LED-1:0] ledr,
    output logic [1:0]       mode
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TK_W   = $clog2(AUTO_DIV);
    localparam int K_STEP = 0;
    localparam int K_MODE = 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0]  TK_LAST  = TK_W'(AUTO_DIV - 1);
    localparam logic [N_LED-1:0] ONE_HOT0 = N_LED'(1);

    function automatic logic [N_LED-1:0] alt_pattern(input logic flag);
        logic [N_LED-1:0] r;
        for (int i = 0; i < N_LED; i++) begin
            r[i] = (i % 2 == 1) ? flag : ~flag;
        end
        return r;
    endfunction

    localparam logic [N_LED-1:0] ALT_INIT = alt_pattern(1'b0);

    typedef enum logic [1:0] {
        MODE_ALT    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BINARY = 2'd3
    } mode_e;

    // Index 0 carries the step key, index 1 the mode key.
    logic [1:0]      key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic            auto_s1_q, auto_s1_d, auto_s2_q, auto_s2_d;
    logic [1:0]      db_level_q, db_level_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      press_q, press_d;
    logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic            tick_q, tick_d;

    mode_e            mode_q, mode_d;
    logic [N_LED-1:0] pattern_q, pattern_d;
    logic             dir_up_q, dir_up_d;
    logic             flag_q, flag_d;
    logic             step;

    always_comb begin
        key_s1_d  = {key_mode, key_step};
        key_s2_d  = key_s1_q;
        auto_s1_d = auto_en;
        auto_s2_d = auto_s1_q;

        // Level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
        for (int k = 0; k < 2; k++) begin
            db_level_d[k] = db_level_q[k];
            db_cnt_d[k]   = '0;
            if (key_s2_q[k] != db_level_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    db_level_d[k] = key_s2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
            press_d[k] = db_level_q[k] & ~db_level_d[k];
        end

        tick_d     = 1'b0;
        tick_cnt_d = '0;
        if (auto_s2_q) begin
            if (tick_cnt_q == TK_LAST) begin
                tick_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    assign step = press_q[K_STEP] | tick_q;

    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        dir_up_d  = dir_up_q;
        flag_d    = flag_q;
        if (press_q[K_MODE]) begin
            flag_d   = 1'b0;
            dir_up_d = 1'b1;
            case (mode_q)
                MODE_ALT: begin
                    mode_d    = MODE_CHASE;
                    pattern_d = ONE_HOT0;
                end
                MODE_CHASE: begin
                    mode_d    = MODE_BOUNCE;
                    pattern_d = ONE_HOT0;
                end
                MODE_BOUNCE: begin
                    mode_d    = MODE_BINARY;
                    pattern_d = '0;
                end
                default: begin
                    mode_d    = MODE_ALT;
                    pattern_d = ALT_INIT;
                end
            endcase
        end else if (step) begin
            case (mode_q)
                MODE_ALT: begin
                    flag_d    = ~flag_q;
                    pattern_d = alt_pattern(~flag_q);
                end
                MODE_CHASE: pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
                MODE_BOUNCE: begin
                    // Direction flips as the lit bit lands on an end, so ends show once.
                    if (dir_up_q) begin
                        pattern_d = pattern_q << 1;
                        dir_up_d  = ~pattern_q[N_LED-2];
                    end else begin
                        pattern_d = pattern_q >> 1;
                        dir_up_d  = pattern_q[1];
                    end
                end
                default: pattern_d = pattern_q + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            key_s1_q   <= 2'b11;
            key_s2_q   <= 2'b11;
            auto_s1_q  <= 1'b0;
            auto_s2_q  <= 1'b0;
            db_level_q <= 2'b11;
            db_cnt_q   <= '{default: '0};
            press_q    <= 2'b00;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            mode_q     <= MODE_ALT;
            pattern_q  <= ALT_INIT;
            dir_up_q   <= 1'b1;
            flag_q     <= 1'b0;
        end else begin
            key_s1_q   <= key_s1_d;
            key_s2_q   <= key_s2_d;
            auto_s1_q  <= auto_s1_d;
            auto_s2_q  <= auto_s2_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            dir_up_q   <= dir_up_d;
            flag_q     <= flag_d;
        end
    end

    assign ledr = pattern_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq with small parameters; expected LED values
// come from a pattern model indexed by (mode, steps since mode entry).
module tb_led_pattern_seq;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int AD = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         key_step = 1'b1;
    logic         key_mode = 1'b1;
    logic         auto_en = 1'b0;
    logic [N-1:0] ledr;
    logic [1:0]   mode;

    int checks   = 0;
    int failures = 0;
    int mode_m   = 0;
    int k_m      = 0;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .N_LED          (N),
        .DEBOUNCE_CYCLES(DB),
        .AUTO_DIV       (AD)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .key_step(key_step),
        .key_mode(key_mode),
        .auto_en (auto_en),
        .ledr    (ledr),
        .mode    (mode)
    );

    // Pattern after k steps in mode m, straight from the pattern definitions.
    function automatic logic [N-1:0] exp_led(input int m, input int k);
        int p;
        case (m)
            0: return (k % 2 == 1) ? 4'b1010 : 4'b0101;
            1: return N'(1 << (k % N));
            2: begin
                p = k % (2 * (N - 1));
                if (p >= N) p = 2 * (N - 1) - p;
                return N'(1 << p);
            end
            default: return N'(k % (1 << N));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_led"}, 32'(ledr), 32'(exp_led(mode_m, k_m)));
        check({tag, "_mode"}, 32'(mode), 32'(mode_m));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Optional short glitch (too short to debounce), then a real press and release.
    task automatic press(input bit s, input bit m, input string tag);
        if ($urandom_range(0, 1) == 1) begin
            if (s) key_step = 1'b0;
            if (m) key_mode = 1'b0;
            cycles($urandom_range(1, 3));
            key_step = 1'b1;
            key_mode = 1'b1;
            cycles(3);
        end
        if (s) key_step = 1'b0;
        if (m) key_mode = 1'b0;
        cycles(8 + $urandom_range(0, 4));
        key_step = 1'b1;
        key_mode = 1'b1;
        cycles(7 + $urandom_range(0, 3));
        if (m) begin
            mode_m = (mode_m + 1) % 4;
            k_m    = 0;
        end else if (s) begin
            k_m++;
        end
        check_state(tag);
    endtask

    initial begin
        int nk;
        #1 clr = 1'b1;
        #1;
        check("reset_led_async", 32'(ledr), 32'h5);
        check("reset_mode_async", 32'(mode), 32'h0);
        cycles(3);
        clr = 1'b0;
        cycles(2);
        check_state("after_reset");

        for (int i = 0; i < 5; i++) begin
            key_step = 1'b0;
            cycles(3);
            key_step = 1'b1;
            cycles(3);
        end
        check("glitch_led", 32'(ledr), 32'h5);

        key_step = 1'b0;
        cycles(6);
        check("hold_before_accept", 32'(ledr), 32'h5);
        cycles(1);
        check("hold_accepted", 32'(ledr), 32'hA);
        cycles(20);
        check("hold_no_repeat", 32'(ledr), 32'hA);
        key_step = 1'b1;
        cycles(10);
        k_m = 1;
        check_state("release_no_step");
        press(1, 0, "alt_repress");

        press(0, 1, "to_chase");
        check("chase_init", 32'(ledr), 32'h1);
        for (int i = 0; i < 5; i++) press(1, 0, "chase_step");
        check("chase_final", 32'(ledr), 32'h2);

        press(0, 1, "to_bounce");
        for (int i = 0; i < 7; i++) press(1, 0, "bounce_step");
        check("bounce_final", 32'(ledr), 32'h2);

        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("midrun_reset_mode", 32'(mode), 32'h0);
        check("midrun_reset_led", 32'(ledr), 32'h5);
        @(negedge clk);
        clr = 1'b0;
        mode_m = 0;
        k_m    = 0;
        cycles(2);
        check_state("post_midrun_reset");

        press(0, 1, "to_chase2");
        press(0, 1, "to_bounce2");
        press(0, 1, "to_binary");
        for (int i = 0; i < 16; i++) press(1, 0, "bin_step");
        check("bin_wrap", 32'(ledr), 32'h0);

        auto_en = 1'b1;
        cycles(24);
        auto_en = 1'b0;
        cycles(12);
        k_m += 3;
        check_state("auto_24");

        nk = $urandom_range(1, 3);
        auto_en = 1'b1;
        cycles(AD * nk);
        auto_en = 1'b0;
        cycles(12);
        k_m += nk;
        check_state("auto_rand");

        press(0, 1, "to_alt3");
        press(0, 1, "to_chase3");
        press(1, 0, "chase3_a");
        press(1, 0, "chase3_b");
        check("collide_pre", 32'(ledr), 32'h4);
        press(1, 1, "collide_mode_step");
        check("collide_led", 32'(ledr), 32'h1);
        check("collide_mode", 32'(mode), 32'h2);

        auto_en = 1'b1;
        cycles(4);
        key_step = 1'b0;
        cycles(6);
        auto_en = 1'b0;
        check("tick_step_pre", 32'(ledr), 32'h1);
        cycles(1);
        k_m = 1;
        check_state("tick_step_single");
        cycles(10);
        key_step = 1'b1;
        cycles(10);
        check_state("tick_step_settled");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
